// File: rtl/alu_xor_stim_chk_if.sv
// Pad bundle between the stimulus/checker and the dual-ALU XOR-compare macro.
// master drives operands/selects (io[37:18]) and reads the result bundle (io[17:0]).
interface alu_xor_stim_chk_if;
    logic [19:0] drv_out;
    logic [17:0] rsp_in;

    modport master (output drv_out, input rsp_in);
    modport slave  (input drv_out, output rsp_in);
endinterface

// File: rtl/alu_xor_stim_chk.sv
// LFSR-driven self-test for the dual-ALU XOR-compare macro: one vector per LATENCY+2 cycles.
// Define ALU_CHK_XOR_EN to also compare the x and y response bits.
module alu_xor_stim_chk #(
    parameter int NUM_VECTORS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start,
    input  logic [15:0]         seed,
    alu_xor_stim_chk_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [15:0]         vec_count,
    output logic [15:0]         first_fail_vec
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

`ifdef ALU_CHK_XOR_EN
    localparam logic [17:0] CMP_MASK = 18'h3FFF1;
`else
    localparam logic [17:0] CMP_MASK = 18'h3FC30;
`endif
    localparam logic [3:0]  WAIT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [15:0] VEC_LAST  = 16'(NUM_VECTORS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [19:0] r_lfsr;
    logic [19:0] r_drv;
    logic [3:0]  r_wait;
    logic [15:0] r_vec;
    logic [15:0] r_err;
    logic [15:0] r_ff;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;

    logic [17:0] w_expect;
    logic        w_mismatch;
    logic [15:0] w_vec_inc;
    logic        w_last;

    function automatic logic [19:0] f_lfsr_step(input logic [19:0] s);
        return s[0] ? ((s >> 1) ^ 20'h90000) : (s >> 1);
    endfunction

    // Returns {carry, out[3:0]}; subtraction carry is the borrow out of bit 4.
    function automatic logic [4:0] f_lane(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] sel);
        logic [4:0] r;
        unique case (sel)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} - {1'b0, b};
            2'b10:   r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return r;
    endfunction

    // Lane 1 = {A0, B0, sel1}, lane 2 = {A1, B1, sel2}.
    function automatic logic [17:0] f_model(input logic [19:0] d);
        logic [4:0] l1;
        logic [4:0] l2;
        l1 = f_lane(d[3:0],  d[7:4],   d[17:16]);
        l2 = f_lane(d[11:8], d[15:12], d[19:18]);
        return {l1[3:0], l2[3:0], l1[3:0] ^ l2[3:0], l1[4], l2[4], 3'b000, l1[4] ^ l2[4]};
    endfunction

    assign w_expect   = f_model(r_drv);
    assign w_mismatch = |((bus.rsp_in ^ w_expect) & CMP_MASK);
    assign w_vec_inc  = r_vec + 16'd1;
    assign w_last     = (w_vec_inc == VEC_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: if (start) w_state_nxt = S_DRIVE;
            S_DRIVE:        w_state_nxt = (LATENCY > 0) ? S_WAIT : S_CHECK;
            S_WAIT:         if (r_wait == WAIT_LAST) w_state_nxt = S_CHECK;
            S_CHECK:        w_state_nxt = w_last ? S_DONE : S_DRIVE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_lfsr <= '0;
            r_drv  <= '0;
            r_wait <= '0;
            r_vec  <= '0;
            r_err  <= '0;
            r_ff   <= 16'hFFFF;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_lfsr <= {4'hA, seed};
                        r_vec  <= '0;
                        r_err  <= '0;
                        r_ff   <= 16'hFFFF;
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                        r_pass <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    r_drv  <= r_lfsr;
                    r_lfsr <= f_lfsr_step(r_lfsr);
                    r_wait <= '0;
                end
                S_WAIT: r_wait <= r_wait + 4'd1;
                S_CHECK: begin
                    r_vec <= w_vec_inc;
                    if (w_mismatch) begin
                        if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
                        if (r_err == 16'd0)    r_ff  <= r_vec;
                    end
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (r_err == 16'd0) && !w_mismatch;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.drv_out    = r_drv;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign vec_count      = r_vec;
    assign first_fail_vec = r_ff;

endmodule

// File: tb/tb_alu_xor_stim_chk.sv
// Directed bench for alu_xor_stim_chk with a behavioural two-stage ALU macro in the loop.
module tb_alu_xor_stim_chk;

    localparam int NV  = 16;
    localparam int LAT = 2;
    localparam int PER = LAT + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seed;
    logic        busy, done, pass;
    logic [15:0] err_count, vec_count, first_fail_vec;

    alu_xor_stim_chk_if bus ();

    alu_xor_stim_chk #(.NUM_VECTORS(NV), .LATENCY(LAT)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .start          (start),
        .seed           (seed),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .vec_count      (vec_count),
        .first_fail_vec (first_fail_vec)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          fault_mode = 0;
    logic [19:0] gold [NV];
    logic [19:0] drv_seen [NV];
    logic [19:0] drv_hold [NV];
    logic [17:0] mac_p0 = '0;
    logic [17:0] mac_p1 = '0;
    logic [17:0] inj;

    function automatic logic [19:0] tb_step(input logic [19:0] s);
        return s[0] ? ((s >> 1) ^ 20'h90000) : (s >> 1);
    endfunction

    function automatic logic [4:0] tb_lane(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] s);
        int v;
        case (s)
            2'd0: v = int'(a) + int'(b);
            2'd1: v = int'(a) - int'(b);
            2'd2: v = int'(a & b);
            default: v = int'(a | b);
        endcase
        return 5'(v);
    endfunction

    // Macro response; ignored bits [3:1] carry junk on purpose.
    function automatic logic [17:0] macro_rsp(input logic [19:0] d);
        logic [4:0] p, q;
        p = tb_lane(d[3:0],  d[7:4],   d[17:16]);
        q = tb_lane(d[11:8], d[15:12], d[19:18]);
        return {p[3:0], q[3:0], p[3:0] ^ q[3:0], p[4], q[4], 3'b101, p[4] ^ q[4]};
    endfunction

    assign inj = (fault_mode == 1 && bus.drv_out == gold[5]) ? 18'h04000 :
                 (fault_mode == 2)                           ? 18'h00040 : 18'h0;

    always @(posedge clk) begin
        mac_p0 <= macro_rsp(bus.drv_out) ^ inj;
        mac_p1 <= mac_p0;
    end
    assign bus.rsp_in = mac_p1;

    task automatic pulse_start(input logic [15:0] s);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called half a cycle after the start edge; cyc counts edges from it.
    task automatic run_to_done(input int extra_at, output int cyc, output bit tmo);
        cyc = 0;
        tmo = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            cyc = k;
            if ((k - 1) % PER == 0 && (k - 1) / PER < NV) drv_seen[(k - 1) / PER] = bus.drv_out;
            if (k % PER == 0 && k / PER <= NV && k > 0)   drv_hold[k / PER - 1] = bus.drv_out;
            if (k == extra_at) start = 1'b1;
            else if (k == extra_at + 1) start = 1'b0;
            if (done) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        pulse_start(16'h1234);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || bus.drv_out === 20'h0) begin
            errors++;
            $display("FAIL reset_pre: busy=%b drv=%h, need busy=1 drv!=0", busy, bus.drv_out);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, pass} !== 3'b000 || err_count !== 16'h0 || vec_count !== 16'h0 ||
            first_fail_vec !== 16'hFFFF || bus.drv_out !== 20'h0) begin
            errors++;
            $display("FAIL reset_async: b/d/p=%b%b%b err=%h vec=%h ff=%h drv=%h, need 000 0 0 ffff 0",
                     busy, done, pass, err_count, vec_count, first_fail_vec, bus.drv_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_golden;
        int cyc;
        bit tmo;
        fault_mode = 0;
        pulse_start(16'h1234);
        run_to_done(-10, cyc, tmo);
        checks++;
        if (tmo || cyc != 64) begin
            errors++;
            $display("FAIL golden_latency: done after %0d cycles (timeout=%0d), need 64", cyc, tmo);
        end
        checks++;
        if (drv_seen[0] !== 20'hA1234) begin
            errors++;
            $display("FAIL golden_first_drv: got %h, need a1234", drv_seen[0]);
        end
        for (int n = 0; n < NV; n++) begin
            checks++;
            if (drv_seen[n] !== gold[n] || drv_hold[n] !== gold[n]) begin
                errors++;
                $display("FAIL golden_drv[%0d]: drive=%h check=%h, need %h", n, drv_seen[n], drv_hold[n], gold[n]);
            end
        end
        checks++;
        if (pass !== 1'b1 || err_count !== 16'd0 || vec_count !== 16'd16 ||
            first_fail_vec !== 16'hFFFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL golden_result: pass=%b err=%0d vec=%0d ff=%h busy=%b, need 1 0 16 ffff 0",
                     pass, err_count, vec_count, first_fail_vec, busy);
        end
    endtask

    task automatic test_fault;
        int cyc;
        bit tmo;
        fault_mode = 1;
        pulse_start(16'h1234);
        run_to_done(-10, cyc, tmo);
        fault_mode = 0;
        checks++;
        if (tmo || pass !== 1'b0 || err_count !== 16'd1 || first_fail_vec !== 16'd5 || vec_count !== 16'd16) begin
            errors++;
            $display("FAIL fault_vec5: pass=%b err=%0d ff=%0d vec=%0d tmo=%0d, need 0 1 5 16",
                     pass, err_count, first_fail_vec, vec_count, tmo);
        end
    endtask

    task automatic test_start_hold;
        int cyc;
        bit tmo;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL done_held: done=%b err=%0d, need 1 1", done, err_count);
        end
        @(negedge clk);
        seed  = 16'h1234;
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || err_count !== 16'd0 || vec_count !== 16'd0 ||
            first_fail_vec !== 16'hFFFF) begin
            errors++;
            $display("FAIL hold_restart: done=%b busy=%b err=%0d vec=%0d ff=%h, need 0 1 0 0 ffff",
                     done, busy, err_count, vec_count, first_fail_vec);
        end
        @(negedge clk);
        start = 1'b0;
        run_to_done(-10, cyc, tmo);
        checks++;
        if (tmo || cyc != 64 || pass !== 1'b1 || vec_count !== 16'd16) begin
            errors++;
            $display("FAIL hold_run: cyc=%0d pass=%b vec=%0d, need 64 1 16", cyc, pass, vec_count);
        end
    endtask

    task automatic test_start_busy;
        int cyc;
        bit tmo;
        pulse_start(16'h1234);
        run_to_done(30, cyc, tmo);
        checks++;
        if (tmo || cyc != 64 || vec_count !== 16'd16 || pass !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: cyc=%0d vec=%0d pass=%b, need 64 16 1", cyc, vec_count, pass);
        end
    endtask

    task automatic test_reset_midrun;
        int cyc;
        bit tmo;
        pulse_start(16'h1234);
        repeat (13) @(posedge clk);
        #1;
        checks++;
        if (vec_count !== 16'd3 || bus.drv_out !== gold[3]) begin
            errors++;
            $display("FAIL midrun_pre: vec=%0d drv=%h, need 3 %h", vec_count, bus.drv_out, gold[3]);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || vec_count !== 16'd0) begin
            errors++;
            $display("FAIL midrun_nodone: done=%b busy=%b vec=%0d, need 0 0 0", done, busy, vec_count);
        end
        pulse_start(16'h1234);
        run_to_done(-10, cyc, tmo);
        for (int n = 0; n < NV; n++) begin
            checks++;
            if (drv_seen[n] !== gold[n]) begin
                errors++;
                $display("FAIL midrun_drv[%0d]: got %h, need %h", n, drv_seen[n], gold[n]);
            end
        end
        checks++;
        if (tmo || pass !== 1'b1 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL midrun_result: pass=%b err=%0d tmo=%0d, need 1 0", pass, err_count, tmo);
        end
    endtask

    task automatic test_xor_build;
        int cyc;
        bit tmo;
        fault_mode = 2;
        pulse_start(16'h00C3);
        run_to_done(-10, cyc, tmo);
        fault_mode = 0;
`ifdef ALU_CHK_XOR_EN
        checks++;
        if (tmo || pass !== 1'b0 || err_count !== 16'd16 || first_fail_vec !== 16'd0) begin
            errors++;
            $display("FAIL xor_en: pass=%b err=%0d ff=%0d, need 0 16 0", pass, err_count, first_fail_vec);
        end
`else
        checks++;
        if (tmo || pass !== 1'b1 || err_count !== 16'd0 || first_fail_vec !== 16'hFFFF) begin
            errors++;
            $display("FAIL xor_masked: pass=%b err=%0d ff=%h, need 1 0 ffff", pass, err_count, first_fail_vec);
        end
`endif
    endtask

    initial begin
        logic [19:0] g;
        g = 20'hA1234;
        for (int n = 0; n < NV; n++) begin
            gold[n] = g;
            g = tb_step(g);
        end
        rst   = 1'b1;
        start = 1'b0;
        seed  = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_golden;
        test_fault;
        test_start_hold;
        test_start_busy;
        test_reset_midrun;
        test_xor_build;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
